// File: rtl/biriscv_csr_counters_if.sv
// ----------------------------------------------------------------------------
// biriscv_csr_counters_if
//
// Purpose : CSR access bus between the core's CSR unit (master) and the
//           performance counter block (slave). It carries a combinational read
//           port and a single-cycle write strobe.
//
// Signals :
//   csr_raddr_i  [11:0]  read address               (master -> slave)
//   csr_rdata_o  [31:0]  read data, combinational   (slave  -> master)
//   csr_hit_o            read address is implemented (slave -> master)
//   csr_wen_i            write strobe               (master -> slave)
//   csr_waddr_i  [11:0]  write address              (master -> slave)
//   csr_wdata_i  [31:0]  write data                 (master -> slave)
// ----------------------------------------------------------------------------
interface biriscv_csr_counters_if;
   logic [11:0] csr_raddr_i;
   logic [31:0] csr_rdata_o;
   logic        csr_hit_o;
   logic        csr_wen_i;
   logic [11:0] csr_waddr_i;
   logic [31:0] csr_wdata_i;

   // The CSR unit drives addresses and write data and consumes read data.
   modport master (
      output csr_raddr_i, csr_wen_i, csr_waddr_i, csr_wdata_i,
      input  csr_rdata_o, csr_hit_o
   );

   // The counter block decodes addresses and returns read data.
   modport slave (
      input  csr_raddr_i, csr_wen_i, csr_waddr_i, csr_wdata_i,
      output csr_rdata_o, csr_hit_o
   );
endinterface

// File: rtl/biriscv_csr_counters.sv
// ----------------------------------------------------------------------------
// biriscv_csr_counters
//
// Purpose : Machine-mode performance counters: mcycle, minstret, NUM_HPM
//           mhpmcounter/mhpmevent pairs starting at index 3, mcountinhibit and
//           the read-only user shadows (cycle, instret, hpmcounterN).
//           Counters are CNT_WIDTH bits wide and wrap modulo 2^CNT_WIDTH.
//
// Parameters :
//   NUM_HPM   number of mhpmcounter/mhpmevent pairs (0..29)
//   CNT_WIDTH implemented counter width (33..64)
//   EVENT_W   number of event strobe inputs (1..31)
//   RETIRE_W  number of retire lanes (1..2)
//
// Ports :
//   clk_i      clock
//   rst_i      asynchronous, active-high reset
//   retire_i   one bit per instruction retired this cycle
//   event_i    per-cycle event strobes, selected by mhpmevent[4:0] (1-based)
//   csr_bus    CSR read/write bus (slave side of biriscv_csr_counters_if)
//   ovf_irq_o  counter overflow interrupt request
//
// Build option : define CSR_HPM_OVF_IRQ_EN to implement the sticky overflow
//   flag mhpmevent[31] and a registered ovf_irq_o. Without it mhpmevent[31]
//   reads 0 and ovf_irq_o is tied low.
// ----------------------------------------------------------------------------
module biriscv_csr_counters #(
   parameter int NUM_HPM   = 4,
   parameter int CNT_WIDTH = 64,
   parameter int EVENT_W   = 8,
   parameter int RETIRE_W  = 2
)(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [RETIRE_W-1:0]       retire_i,
   input  logic [EVENT_W-1:0]        event_i,
   biriscv_csr_counters_if.slave     csr_bus,
   output logic                      ovf_irq_o
);

   // Arrays need at least one element even when no HPM counters exist.
   localparam int HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;

   // Writable mcountinhibit bits: CY (0), IR (2) and one per HPM counter.
   localparam logic [63:0] INH_MASK64 = ((64'd1 << (NUM_HPM + 3)) - 64'd1) & ~64'd2;
   localparam logic [31:0] INH_MASK   = INH_MASK64[31:0];

   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONES = {CNT_WIDTH{1'b1}};

   localparam logic [11:0] A_MCYCLE      = 12'hB00;
   localparam logic [11:0] A_MCYCLEH     = 12'hB80;
   localparam logic [11:0] A_MINSTRET    = 12'hB02;
   localparam logic [11:0] A_MINSTRETH   = 12'hB82;
   localparam logic [11:0] A_MHPM        = 12'hB03;
   localparam logic [11:0] A_MHPMH       = 12'hB83;
   localparam logic [11:0] A_CYCLE       = 12'hC00;
   localparam logic [11:0] A_CYCLEH      = 12'hC80;
   localparam logic [11:0] A_INSTRET     = 12'hC02;
   localparam logic [11:0] A_INSTRETH    = 12'hC82;
   localparam logic [11:0] A_HPM         = 12'hC03;
   localparam logic [11:0] A_HPMH        = 12'hC83;
   localparam logic [11:0] A_MCOUNTINHIB = 12'h320;
   localparam logic [11:0] A_MHPMEVENT   = 12'h323;

   logic [CNT_WIDTH-1:0] r_mcycle;
   logic [CNT_WIDTH-1:0] r_minstret;
   logic [CNT_WIDTH-1:0] r_hpm     [HPM_N];
   logic [4:0]           r_evt_sel [HPM_N];
   logic [31:0]          r_inhibit;

   logic                 w_wr_mcycle_lo;
   logic                 w_wr_mcycle_hi;
   logic                 w_wr_minstret_lo;
   logic                 w_wr_minstret_hi;
   logic                 w_wr_inhibit;
   logic [HPM_N-1:0]     w_wr_hpm_lo;
   logic [HPM_N-1:0]     w_wr_hpm_hi;
   logic [HPM_N-1:0]     w_wr_evt;
   logic [HPM_N-1:0]     w_inc_hpm;
   logic [HPM_N-1:0]     w_of;
   logic [CNT_WIDTH-1:0] w_retire_cnt;
   logic [31:0]          w_evt_vec;
   logic [31:0]          w_wdata;

   assign w_wdata = csr_bus.csr_wdata_i;

   // Replaces one 32-bit half of a counter. Working in a 64-bit image lets
   // bits at or above CNT_WIDTH fall away when the result is truncated.
   function automatic logic [CNT_WIDTH-1:0] f_load(input logic [CNT_WIDTH-1:0] cur,
                                                  input logic                  hi,
                                                  input logic [31:0]           wd);
      logic [63:0] v;
      v = 64'(cur);
      if (hi) v[63:32] = wd;
      else    v[31:0]  = wd;
      return v[CNT_WIDTH-1:0];
   endfunction

   // Returns one 32-bit half of a counter; unimplemented upper bits read 0.
   function automatic logic [31:0] f_half(input logic [CNT_WIDTH-1:0] cur,
                                          input logic                  hi);
      logic [63:0] v;
      v = 64'(cur);
      return hi ? v[63:32] : v[31:0];
   endfunction

   // Event selects are 1-based: shifting the strobes up by one makes select 0
   // and any select beyond EVENT_W land on a constant-zero bit.
   assign w_evt_vec = 32'(event_i) << 1;

   // Number of instructions retired this cycle (0..RETIRE_W).
   always_comb begin
      w_retire_cnt = '0;
      for (int r = 0; r < RETIRE_W; r++) begin
         w_retire_cnt = w_retire_cnt + CNT_WIDTH'(retire_i[r]);
      end
   end

   // Write address decode. Only the machine-mode addresses are writable; the
   // user shadows at 0xCxx are deliberately absent so writes to them vanish.
   always_comb begin
      w_wr_mcycle_lo   = 1'b0;
      w_wr_mcycle_hi   = 1'b0;
      w_wr_minstret_lo = 1'b0;
      w_wr_minstret_hi = 1'b0;
      w_wr_inhibit     = 1'b0;
      w_wr_hpm_lo      = '0;
      w_wr_hpm_hi      = '0;
      w_wr_evt         = '0;
      if (csr_bus.csr_wen_i) begin
         w_wr_mcycle_lo   = (csr_bus.csr_waddr_i == A_MCYCLE);
         w_wr_mcycle_hi   = (csr_bus.csr_waddr_i == A_MCYCLEH);
         w_wr_minstret_lo = (csr_bus.csr_waddr_i == A_MINSTRET);
         w_wr_minstret_hi = (csr_bus.csr_waddr_i == A_MINSTRETH);
         w_wr_inhibit     = (csr_bus.csr_waddr_i == A_MCOUNTINHIB);
         for (int i = 0; i < NUM_HPM; i++) begin
            w_wr_hpm_lo[i] = (csr_bus.csr_waddr_i == A_MHPM      + 12'(i));
            w_wr_hpm_hi[i] = (csr_bus.csr_waddr_i == A_MHPMH     + 12'(i));
            w_wr_evt[i]    = (csr_bus.csr_waddr_i == A_MHPMEVENT + 12'(i));
         end
      end
   end

   // An HPM counter advances when its selected event fires, it is not
   // inhibited, and software is not writing either half of it this cycle.
   always_comb begin
      w_inc_hpm = '0;
      for (int i = 0; i < NUM_HPM; i++) begin
         w_inc_hpm[i] = w_evt_vec[r_evt_sel[i]] && !r_inhibit[3 + i] &&
                        !w_wr_hpm_lo[i] && !w_wr_hpm_hi[i];
      end
   end

   // Counter and configuration registers. A CSR write to a counter replaces
   // the increment for that counter only; every other counter keeps counting.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_mcycle   <= '0;
         r_minstret <= '0;
         r_inhibit  <= '0;
         for (int i = 0; i < HPM_N; i++) begin
            r_hpm[i]     <= '0;
            r_evt_sel[i] <= '0;
         end
      end else begin
         if (w_wr_mcycle_lo || w_wr_mcycle_hi) begin
            r_mcycle <= f_load(r_mcycle, w_wr_mcycle_hi, w_wdata);
         end else if (!r_inhibit[0]) begin
            r_mcycle <= r_mcycle + CNT_ONE;
         end

         if (w_wr_minstret_lo || w_wr_minstret_hi) begin
            r_minstret <= f_load(r_minstret, w_wr_minstret_hi, w_wdata);
         end else if (!r_inhibit[2]) begin
            r_minstret <= r_minstret + w_retire_cnt;
         end

         if (w_wr_inhibit) begin
            r_inhibit <= w_wdata & INH_MASK;
         end

         for (int i = 0; i < NUM_HPM; i++) begin
            if (w_wr_hpm_lo[i] || w_wr_hpm_hi[i]) begin
               r_hpm[i] <= f_load(r_hpm[i], w_wr_hpm_hi[i], w_wdata);
            end else if (w_inc_hpm[i]) begin
               r_hpm[i] <= r_hpm[i] + CNT_ONE;
            end
            if (w_wr_evt[i]) begin
               r_evt_sel[i] <= w_wdata[4:0];
            end
         end
      end
   end

`ifdef CSR_HPM_OVF_IRQ_EN
   logic [HPM_N-1:0] r_of;
   logic [HPM_N-1:0] w_of_next;
   logic             r_ovf_irq;

   // OF is set when an increment carries the counter from all-ones to zero.
   // That wrap outranks a software write in the same cycle, so a clear racing
   // with a fresh overflow never loses the event.
   always_comb begin
      w_of_next = r_of;
      for (int i = 0; i < NUM_HPM; i++) begin
         if (w_inc_hpm[i] && (r_hpm[i] == CNT_ONES)) begin
            w_of_next[i] = 1'b1;
         end else if (w_wr_evt[i]) begin
            w_of_next[i] = w_wdata[31];
         end
      end
   end

   // The interrupt flop follows the OF bits it summarises, so it rises and
   // falls on the same edge as the flags themselves.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_of      <= '0;
         r_ovf_irq <= 1'b0;
      end else begin
         r_of      <= w_of_next;
         r_ovf_irq <= |w_of_next;
      end
   end

   assign w_of      = r_of;
   assign ovf_irq_o = r_ovf_irq;
`else
   assign w_of      = '0;
   assign ovf_irq_o = 1'b0;
`endif

   // Combinational read port from registered state. The user shadows decode
   // to the same registers as their machine-mode counterparts.
   always_comb begin
      csr_bus.csr_rdata_o = '0;
      csr_bus.csr_hit_o   = 1'b0;
      case (csr_bus.csr_raddr_i)
         A_MCYCLE, A_CYCLE: begin
            csr_bus.csr_hit_o   = 1'b1;
            csr_bus.csr_rdata_o = f_half(r_mcycle, 1'b0);
         end
         A_MCYCLEH, A_CYCLEH: begin
            csr_bus.csr_hit_o   = 1'b1;
            csr_bus.csr_rdata_o = f_half(r_mcycle, 1'b1);
         end
         A_MINSTRET, A_INSTRET: begin
            csr_bus.csr_hit_o   = 1'b1;
            csr_bus.csr_rdata_o = f_half(r_minstret, 1'b0);
         end
         A_MINSTRETH, A_INSTRETH: begin
            csr_bus.csr_hit_o   = 1'b1;
            csr_bus.csr_rdata_o = f_half(r_minstret, 1'b1);
         end
         A_MCOUNTINHIB: begin
            csr_bus.csr_hit_o   = 1'b1;
            csr_bus.csr_rdata_o = r_inhibit;
         end
         default: begin
         end
      endcase
      for (int i = 0; i < NUM_HPM; i++) begin
         if ((csr_bus.csr_raddr_i == A_MHPM + 12'(i)) ||
             (csr_bus.csr_raddr_i == A_HPM  + 12'(i))) begin
            csr_bus.csr_hit_o   = 1'b1;
            csr_bus.csr_rdata_o = f_half(r_hpm[i], 1'b0);
         end
         if ((csr_bus.csr_raddr_i == A_MHPMH + 12'(i)) ||
             (csr_bus.csr_raddr_i == A_HPMH  + 12'(i))) begin
            csr_bus.csr_hit_o   = 1'b1;
            csr_bus.csr_rdata_o = f_half(r_hpm[i], 1'b1);
         end
         if (csr_bus.csr_raddr_i == A_MHPMEVENT + 12'(i)) begin
            csr_bus.csr_hit_o   = 1'b1;
            csr_bus.csr_rdata_o = {w_of[i], 26'd0, r_evt_sel[i]};
         end
      end
   end

endmodule

// File: tb/tb_biriscv_csr_counters.sv
// ----------------------------------------------------------------------------
// tb_biriscv_csr_counters
//
// Self-checking bench for biriscv_csr_counters (CNT_WIDTH=40, NUM_HPM=4,
// EVENT_W=8, RETIRE_W=2). A table of directed steps with hand-derived
// expectations, hand-written reset and overflow sequences, then randomized
// traffic compared against a behavioural counter model.
// ----------------------------------------------------------------------------
module tb_biriscv_csr_counters;
   localparam int NUM_HPM   = 4;
   localparam int CNT_WIDTH = 40;
   localparam int EVENT_W   = 8;
   localparam int RETIRE_W  = 2;
   localparam longint unsigned CNT_MASK = (64'd1 << CNT_WIDTH) - 64'd1;

   logic                clk_i;
   logic                rst_i;
   logic [RETIRE_W-1:0] retire_i;
   logic [EVENT_W-1:0]  event_i;
   logic                ovf_irq_o;

   biriscv_csr_counters_if csrBus();

   biriscv_csr_counters #(
      .NUM_HPM  (NUM_HPM),
      .CNT_WIDTH(CNT_WIDTH),
      .EVENT_W  (EVENT_W),
      .RETIRE_W (RETIRE_W)
   ) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .retire_i (retire_i),
      .event_i  (event_i),
      .csr_bus  (csrBus),
      .ovf_irq_o(ovf_irq_o)
   );

   // 10 ns clock
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   // Behavioural model state: plain integers, wrapped by masking.
   longint unsigned mCycle;
   longint unsigned mInstret;
   longint unsigned mHpm [NUM_HPM];
   logic [4:0]      mSel [NUM_HPM];
   bit              mOf  [NUM_HPM];
   logic [31:0]     mInhibit;
   bit              mIrq;

   task automatic modelReset();
      mCycle = 0; mInstret = 0; mInhibit = 0; mIrq = 0;
      for (int i = 0; i < NUM_HPM; i++) begin
         mHpm[i] = 0; mSel[i] = 0; mOf[i] = 0;
      end
   endtask

   function automatic longint unsigned loadHalf(input longint unsigned cur, input bit hi,
                                                input logic [31:0] wd);
      longint unsigned v;
      if (hi) v = (longint'(wd) << 32) | (cur & 64'h0000_0000_FFFF_FFFF);
      else    v = (cur & 64'hFFFF_FFFF_0000_0000) | longint'(wd);
      return v & CNT_MASK;
   endfunction

   // One clock of the counter rules, all decisions made on pre-edge state.
   task automatic modelStep(input logic [1:0] ret, input logic [7:0] evt, input bit wen,
                            input logic [11:0] wa, input logic [31:0] wd);
      longint unsigned nHpm [NUM_HPM];
      bit nOf [NUM_HPM];
      logic [4:0] nSel [NUM_HPM];
      logic [31:0] nInh;
      int k;
      bit fire;
      bit wrapped;
      nInh = mInhibit;
      if (wen && wa == 12'h320) nInh = wd & 32'h0000_007D;
      for (int i = 0; i < NUM_HPM; i++) begin
         nHpm[i] = mHpm[i]; nOf[i] = mOf[i]; nSel[i] = mSel[i];
         k = int'(mSel[i]);
         fire = (k >= 1 && k <= EVENT_W) ? evt[k-1] : 1'b0;
         wrapped = 0;
         if (wen && wa == 12'hB03 + 12'(i))      nHpm[i] = loadHalf(mHpm[i], 0, wd);
         else if (wen && wa == 12'hB83 + 12'(i)) nHpm[i] = loadHalf(mHpm[i], 1, wd);
         else if (fire && !mInhibit[3+i]) begin
            wrapped = (mHpm[i] == CNT_MASK);
            nHpm[i] = (mHpm[i] + 1) & CNT_MASK;
         end
         if (wen && wa == 12'h323 + 12'(i)) nSel[i] = wd[4:0];
`ifdef CSR_HPM_OVF_IRQ_EN
         if (wrapped) nOf[i] = 1;
         else if (wen && wa == 12'h323 + 12'(i)) nOf[i] = wd[31];
`endif
      end
      if (wen && wa == 12'hB00)      mCycle = loadHalf(mCycle, 0, wd);
      else if (wen && wa == 12'hB80) mCycle = loadHalf(mCycle, 1, wd);
      else if (!mInhibit[0])         mCycle = (mCycle + 1) & CNT_MASK;
      if (wen && wa == 12'hB02)      mInstret = loadHalf(mInstret, 0, wd);
      else if (wen && wa == 12'hB82) mInstret = loadHalf(mInstret, 1, wd);
      else if (!mInhibit[2])         mInstret = (mInstret + $countones(ret)) & CNT_MASK;
      mInhibit = nInh;
      mIrq = 0;
      for (int i = 0; i < NUM_HPM; i++) begin
         mHpm[i] = nHpm[i]; mOf[i] = nOf[i]; mSel[i] = nSel[i];
         mIrq = mIrq | nOf[i];
      end
   endtask

   task automatic modelRead(input logic [11:0] a, output logic [31:0] d, output bit h);
      longint unsigned v;
      bit isCnt;
      bit hiHalf;
      d = 0; h = 0; v = 0; isCnt = 0; hiHalf = 0;
      case (a)
         12'hB00, 12'hC00: begin isCnt = 1; v = mCycle; end
         12'hB80, 12'hC80: begin isCnt = 1; hiHalf = 1; v = mCycle; end
         12'hB02, 12'hC02: begin isCnt = 1; v = mInstret; end
         12'hB82, 12'hC82: begin isCnt = 1; hiHalf = 1; v = mInstret; end
         12'h320:          begin h = 1; d = mInhibit; end
         default: ;
      endcase
      for (int i = 0; i < NUM_HPM; i++) begin
         if (a == 12'hB03 + 12'(i) || a == 12'hC03 + 12'(i)) begin isCnt = 1; v = mHpm[i]; end
         if (a == 12'hB83 + 12'(i) || a == 12'hC83 + 12'(i)) begin isCnt = 1; hiHalf = 1; v = mHpm[i]; end
         if (a == 12'h323 + 12'(i)) begin h = 1; d = {mOf[i], 26'd0, mSel[i]}; end
      end
      if (isCnt) begin
         h = 1;
         d = hiHalf ? v[63:32] : v[31:0];
      end
   endtask

   // Drive one cycle of inputs, clock once, advance the model with them.
   task automatic applyStimulus(input logic [1:0] ret, input logic [7:0] evt, input bit wen,
                                input logic [11:0] wa, input logic [31:0] wd);
      retire_i = ret;
      event_i  = evt;
      csrBus.csr_wen_i   = wen;
      csrBus.csr_waddr_i = wa;
      csrBus.csr_wdata_i = wd;
      @(posedge clk_i);
      #1;
      modelStep(ret, evt, wen, wa, wd);
      csrBus.csr_wen_i = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [11:0] addr,
                              input logic [31:0] expData, input bit expHit);
      csrBus.csr_raddr_i = addr;
      #1;
      checks++;
      if (csrBus.csr_rdata_o !== expData || csrBus.csr_hit_o !== expHit) begin
         errors++;
         $display("[TB] FAIL %s addr=%h: got rdata=%h hit=%b, expected rdata=%h hit=%b",
                  name, addr, csrBus.csr_rdata_o, csrBus.csr_hit_o, expData, expHit);
      end
   endtask

   task automatic checkIrq(input string name, input bit expIrq);
      checks++;
      if (ovf_irq_o !== expIrq) begin
         errors++;
         $display("[TB] FAIL %s ovf_irq_o: got %b, expected %b", name, ovf_irq_o, expIrq);
      end
   endtask

   task automatic applyReset();
      retire_i = '0; event_i = '0;
      csrBus.csr_wen_i = 1'b0; csrBus.csr_waddr_i = '0; csrBus.csr_wdata_i = '0;
      csrBus.csr_raddr_i = '0;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      modelReset();
   endtask

   typedef struct {
      int          nclk;
      logic [1:0]  ret;
      logic [7:0]  evt;
      bit          wen;
      logic [11:0] waddr;
      logic [31:0] wdata;
      logic [11:0] raddr;
      logic [31:0] expData;
      bit          expHit;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input int n, input logic [1:0] r, input logic [7:0] e, input bit w,
                         input logic [11:0] wa, input logic [31:0] wd, input logic [11:0] ra,
                         input logic [31:0] ed, input bit eh);
      vec_t v;
      v.nclk = n; v.ret = r; v.evt = e; v.wen = w; v.waddr = wa; v.wdata = wd;
      v.raddr = ra; v.expData = ed; v.expHit = eh;
      vecs.push_back(v);
   endtask

   logic [11:0] addrList [0:19] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04,
                                    12'hB05, 12'hB06, 12'hB83, 12'hB84, 12'hB85, 12'hB86,
                                    12'h320, 12'h323, 12'h324, 12'h325, 12'h326, 12'hC00,
                                    12'hC83, 12'hB07};

   initial begin
      logic [31:0] md;
      bit          mh;
      logic [11:0] wa;
      logic [31:0] wd;

      rst_i = 1'b1;
      retire_i = '0; event_i = '0;
      csrBus.csr_wen_i = 1'b0; csrBus.csr_waddr_i = '0; csrBus.csr_wdata_i = '0;
      csrBus.csr_raddr_i = '0;

      // Directed table: every expectation derived by hand from the counter rules.
      addVec(0, 0, 0, 0, 0, 0, 12'hB00, 32'h0, 1);
      addVec(0, 0, 0, 0, 0, 0, 12'h320, 32'h0, 1);
      addVec(0, 0, 0, 0, 0, 0, 12'h323, 32'h0, 1);
      addVec(10, 0, 0, 0, 0, 0, 12'hB00, 32'd10, 1);
      addVec(0, 0, 0, 0, 0, 0, 12'hC00, 32'd10, 1);
      addVec(0, 0, 0, 0, 0, 0, 12'hB80, 32'd0, 1);
      addVec(5, 3, 0, 0, 0, 0, 12'hB02, 32'd10, 1);
      addVec(3, 1, 0, 0, 0, 0, 12'hB02, 32'd13, 1);
      addVec(0, 0, 0, 0, 0, 0, 12'hC02, 32'd13, 1);
      addVec(0, 0, 0, 0, 0, 0, 12'hB07, 32'd0, 0);
      addVec(0, 0, 0, 0, 0, 0, 12'hB01, 32'd0, 0);
      addVec(0, 0, 0, 0, 0, 0, 12'hC87, 32'd0, 0);
      addVec(0, 0, 0, 0, 0, 0, 12'h327, 32'd0, 0);
      addVec(1, 0, 0, 1, 12'hB00, 32'hFFFF_FFFF, 12'hB00, 32'hFFFF_FFFF, 1);
      addVec(1, 0, 0, 0, 0, 0, 12'hB80, 32'd1, 1);
      addVec(0, 0, 0, 0, 0, 0, 12'hB00, 32'd0, 1);
      addVec(1, 0, 0, 1, 12'hC00, 32'h1234, 12'hB00, 32'd1, 1);
      addVec(0, 0, 0, 0, 0, 0, 12'hC00, 32'd1, 1);
      addVec(1, 0, 0, 1, 12'hB80, 32'hFFFF_FFFF, 12'hB80, 32'hFF, 1);
      addVec(0, 0, 0, 0, 0, 0, 12'hB00, 32'd1, 1);
      addVec(1, 0, 0, 1, 12'hB00, 32'hFFFF_FFFF, 12'hB00, 32'hFFFF_FFFF, 1);
      addVec(1, 0, 0, 0, 0, 0, 12'hB80, 32'd0, 1);
      addVec(0, 0, 0, 0, 0, 0, 12'hB00, 32'd0, 1);
      addVec(1, 0, 0, 1, 12'hB02, 32'hFFFF_FFFF, 12'hB02, 32'hFFFF_FFFF, 1);
      addVec(1, 0, 0, 1, 12'hB82, 32'hFF, 12'hB82, 32'hFF, 1);
      addVec(1, 3, 0, 0, 0, 0, 12'hB02, 32'd1, 1);
      addVec(0, 0, 0, 0, 0, 0, 12'hB82, 32'd0, 1);
      addVec(1, 3, 0, 1, 12'hB02, 32'd5, 12'hB02, 32'd5, 1);
      addVec(1, 0, 0, 1, 12'h323, 32'd2, 12'h323, 32'd2, 1);
      addVec(7, 0, 8'h02, 0, 0, 0, 12'hB03, 32'd7, 1);
      addVec(1, 0, 0, 1, 12'h320, 32'h8, 12'h320, 32'h8, 1);
      addVec(3, 0, 8'h02, 0, 0, 0, 12'hB03, 32'd7, 1);
      addVec(1, 0, 0, 1, 12'h320, 32'hFFFF_FFFF, 12'h320, 32'h7D, 1);
      addVec(1, 0, 0, 1, 12'hB00, 32'h100, 12'hB00, 32'h100, 1);
      addVec(4, 3, 8'hFF, 0, 0, 0, 12'hB00, 32'h100, 1);
      addVec(0, 0, 0, 0, 0, 0, 12'hB02, 32'd5, 1);
      addVec(0, 0, 0, 0, 0, 0, 12'hB03, 32'd7, 1);
      addVec(1, 0, 0, 1, 12'h320, 32'h0, 12'hB00, 32'h100, 1);
      addVec(1, 0, 0, 0, 0, 0, 12'hB00, 32'h101, 1);
      addVec(1, 0, 0, 1, 12'h324, 32'd9, 12'h324, 32'd9, 1);
      addVec(3, 0, 8'hFF, 0, 0, 0, 12'hB04, 32'd0, 1);
      addVec(1, 0, 0, 1, 12'h324, 32'h28, 12'h324, 32'h8, 1);
      addVec(2, 0, 8'h80, 0, 0, 0, 12'hB04, 32'd2, 1);
      addVec(0, 0, 0, 0, 0, 0, 12'hC04, 32'd2, 1);
      addVec(0, 0, 0, 0, 0, 0, 12'hB05, 32'd0, 1);
      addVec(1, 0, 0, 1, 12'hB83, 32'h1234_5678, 12'hB83, 32'h78, 1);
      addVec(1, 0, 0, 1, 12'hC03, 32'd5, 12'hC03, 32'hA, 1);
      addVec(1, 0, 0, 1, 12'h323, 32'h1F, 12'h323, 32'h1F, 1);

      applyReset();
      foreach (vecs[n]) begin
         for (int c = 0; c < vecs[n].nclk; c++) begin
            applyStimulus(vecs[n].ret, vecs[n].evt, vecs[n].wen, vecs[n].waddr, vecs[n].wdata);
         end
         checkOutput($sformatf("vec%0d", n), vecs[n].raddr, vecs[n].expData, vecs[n].expHit);
      end
      checkIrq("table_irq", 1'b0);

      // Reset asserted mid-cycle clears state without waiting for a clock edge.
      rst_i = 1'b1;
      #1;
      checkOutput("async_rst_mcycle", 12'hB00, 32'd0, 1);
      checkOutput("async_rst_sel", 12'h324, 32'd0, 1);
      checkIrq("async_rst_irq", 1'b0);
      // A write presented while reset is held is discarded.
      csrBus.csr_wen_i = 1'b1; csrBus.csr_waddr_i = 12'hB00; csrBus.csr_wdata_i = 32'h55;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      csrBus.csr_wen_i = 1'b0;
      modelReset();
      checkOutput("rst_write_discard", 12'hB00, 32'd0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("resume_count", 12'hB00, 32'd1, 1);

      // Overflow behaviour around mhpmcounter3 wrapping at 40 bits.
      applyReset();
      applyStimulus(0, 0, 1, 12'h323, 32'd2);
      applyStimulus(0, 0, 1, 12'hB03, 32'hFFFF_FFFF);
      applyStimulus(0, 0, 1, 12'hB83, 32'hFF);
      checkOutput("ovf_load_hi", 12'hB83, 32'hFF, 1);
      checkIrq("ovf_before", 1'b0);
      applyStimulus(0, 8'h02, 0, 0, 0);
      checkOutput("ovf_wrap_lo", 12'hB03, 32'd0, 1);
      checkOutput("ovf_wrap_hi", 12'hB83, 32'd0, 1);
`ifdef CSR_HPM_OVF_IRQ_EN
      checkOutput("ovf_of_set", 12'h323, 32'h8000_0002, 1);
      checkIrq("ovf_irq_set", 1'b1);
      applyStimulus(0, 0, 0, 0, 0);
      checkIrq("ovf_irq_sticky", 1'b1);
      applyStimulus(0, 0, 1, 12'h323, 32'd2);
      checkIrq("ovf_irq_clear", 1'b0);
      checkOutput("ovf_of_clear", 12'h323, 32'd2, 1);
      applyStimulus(0, 0, 1, 12'hB03, 32'hFFFF_FFFF);
      applyStimulus(0, 0, 1, 12'hB83, 32'hFF);
      applyStimulus(0, 8'h02, 1, 12'h323, 32'd2);
      checkOutput("ovf_wrap_beats_clear", 12'h323, 32'h8000_0002, 1);
      checkIrq("ovf_wrap_beats_clear_irq", 1'b1);
`else
      checkOutput("of_absent", 12'h323, 32'd2, 1);
      checkIrq("irq_tied_low", 1'b0);
      applyStimulus(0, 0, 1, 12'h323, 32'h8000_0002);
      checkOutput("of_write_ignored", 12'h323, 32'd2, 1);
      checkIrq("irq_tied_low2", 1'b0);
`endif

      // Randomized traffic against the behavioural model.
      applyReset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         wa = addrList[$urandom_range(0, 19)];
         case ($urandom_range(0, 3))
            0: wd = 32'hFFFF_FFFF;
            1: wd = $urandom_range(0, 10);
            2: wd = $urandom;
            default: wd = 32'hFFFF_FFFE;
         endcase
         applyStimulus(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                       ($urandom_range(0, 2) == 0), wa, wd);
         checkIrq($sformatf("rand_irq%0d", cyc), mIrq);
         wa = addrList[$urandom_range(0, 19)];
         modelRead(wa, md, mh);
         checkOutput($sformatf("rand_rd%0d", cyc), wa, md, mh);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
